// File: rtl/m20k_port_arbiter.sv
// Dual-requester write/read arbiter in front of a single M20K-style memory.
// Clears the whole array after reset, then round-robins writes and reads independently.
module m20k_port_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrReqA,
  input  logic              wrReqB,
  input  logic [ADDR_W-1:0] wrAddrA,
  input  logic [ADDR_W-1:0] wrAddrB,
  input  logic [1:0]        wrMaskA,
  input  logic [1:0]        wrMaskB,
  input  logic [19:0]       wrDataA,
  input  logic [19:0]       wrDataB,
  output logic              wrGntA,
  output logic              wrGntB,
  input  logic              rdReqA,
  input  logic              rdReqB,
  input  logic [ADDR_W-1:0] rdAddrA,
  input  logic [ADDR_W-1:0] rdAddrB,
  output logic              rdGntA,
  output logic              rdGntB,
  output logic              rdDataValid,
  output logic              rdDataOwner,
  output logic [19:0]       rdData,
  output logic              memWriteEnable,
  output logic [ADDR_W-1:0] memWriteAddr,
  output logic [1:0]        memWriteMask,
  output logic [19:0]       memWriteData,
  output logic              memReadEnable,
  output logic [ADDR_W-1:0] memReadAddr,
  input  logic [19:0]       memReadData,
  output logic              busy
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       clr_cnt_q, clr_cnt_d;
  logic                    wr_pri_q, wr_pri_d;
  logic                    rd_pri_q, rd_pri_d;
  logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [READ_LATENCY-1:0] pipe_own_q, pipe_own_d;

  logic              wr_sel, rd_sel, wr_go, rd_go;
  logic [ADDR_W-1:0] wr_addr_w, rd_addr_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_cnt_q  <= '0;
      wr_pri_q   <= 1'b0;
      rd_pri_q   <= 1'b0;
      pipe_vld_q <= '0;
      pipe_own_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      wr_pri_q   <= wr_pri_d;
      rd_pri_q   <= rd_pri_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_own_q <= pipe_own_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    clr_cnt_d      = clr_cnt_q;
    wr_pri_d       = wr_pri_q;
    rd_pri_d       = rd_pri_q;
    wrGntA         = 1'b0;
    wrGntB         = 1'b0;
    rdGntA         = 1'b0;
    rdGntB         = 1'b0;
    memWriteEnable = 1'b0;
    memWriteAddr   = '0;
    memWriteMask   = '0;
    memWriteData   = '0;
    memReadEnable  = 1'b0;
    memReadAddr    = '0;
    wr_go          = 1'b0;
    rd_go          = 1'b0;
    busy           = rst || (state_q == ST_CLEAR);

    // Selected side: 0=A, 1=B; priority bit only matters on contention
    wr_sel    = (wrReqA && wrReqB) ? wr_pri_q : ~wrReqA;
    rd_sel    = (rdReqA && rdReqB) ? rd_pri_q : ~rdReqA;
    wr_addr_w = wr_sel ? wrAddrB : wrAddrA;
    rd_addr_w = rd_sel ? rdAddrB : rdAddrA;

    case (state_q)
      ST_CLEAR: begin
        if (!rst) begin
          memWriteEnable = 1'b1;
          memWriteMask   = 2'b11;
          memWriteAddr   = clr_cnt_q;
          clr_cnt_d      = clr_cnt_q + 1'b1;
          if (clr_cnt_q == '1) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!rst) begin
          wr_go = wrReqA || wrReqB;
          // A read colliding with this cycle's write waits, so it returns the new data
          rd_go = (rdReqA || rdReqB) && !(wr_go && (rd_addr_w == wr_addr_w));
          if (wr_go) begin
            wrGntA         = ~wr_sel;
            wrGntB         = wr_sel;
            memWriteEnable = 1'b1;
            memWriteAddr   = wr_addr_w;
            memWriteMask   = wr_sel ? wrMaskB : wrMaskA;
            memWriteData   = wr_sel ? wrDataB : wrDataA;
            wr_pri_d       = ~wr_sel;
          end
          if (rd_go) begin
            rdGntA        = ~rd_sel;
            rdGntB        = rd_sel;
            memReadEnable = 1'b1;
            memReadAddr   = rd_addr_w;
            rd_pri_d      = ~rd_sel;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase

    pipe_vld_d    = pipe_vld_q << 1;
    pipe_vld_d[0] = rd_go;
    pipe_own_d    = pipe_own_q << 1;
    pipe_own_d[0] = rd_go && rd_sel;
  end

  assign rdDataValid = pipe_vld_q[READ_LATENCY-1] && !rst;
  assign rdDataOwner = pipe_own_q[READ_LATENCY-1] && rdDataValid;
  assign rdData      = rdDataValid ? memReadData : '0;

endmodule

// File: tb/tb_m20k_port_arbiter.sv
// Bench for m20k_port_arbiter: directed table, multi-cycle corner sequences,
// and random traffic against a queue-based memory/arbitration reference.
module tb_m20k_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrReqA, wrReqB, rdReqA, rdReqB;
  logic [9:0]  wrAddrA, wrAddrB, rdAddrA, rdAddrB;
  logic [1:0]  wrMaskA, wrMaskB;
  logic [19:0] wrDataA, wrDataB;
  logic        wrGntA, wrGntB, rdGntA, rdGntB;
  logic        rdDataValid, rdDataOwner;
  logic [19:0] rdData;
  logic        memWriteEnable, memReadEnable;
  logic [9:0]  memWriteAddr, memReadAddr;
  logic [1:0]  memWriteMask;
  logic [19:0] memWriteData, memReadData;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  m20k_port_arbiter #(.ADDR_W(10), .READ_LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .wrReqA(wrReqA), .wrReqB(wrReqB), .wrAddrA(wrAddrA), .wrAddrB(wrAddrB),
    .wrMaskA(wrMaskA), .wrMaskB(wrMaskB), .wrDataA(wrDataA), .wrDataB(wrDataB),
    .wrGntA(wrGntA), .wrGntB(wrGntB),
    .rdReqA(rdReqA), .rdReqB(rdReqB), .rdAddrA(rdAddrA), .rdAddrB(rdAddrB),
    .rdGntA(rdGntA), .rdGntB(rdGntB),
    .rdDataValid(rdDataValid), .rdDataOwner(rdDataOwner), .rdData(rdData),
    .memWriteEnable(memWriteEnable), .memWriteAddr(memWriteAddr),
    .memWriteMask(memWriteMask), .memWriteData(memWriteData),
    .memReadEnable(memReadEnable), .memReadAddr(memReadAddr),
    .memReadData(memReadData), .busy(busy)
  );

  // Memory environment: masked writes, two-cycle registered read
  logic [19:0] env_mem [0:1023];
  logic [19:0] env_rd1, env_rd2;
  always @(posedge clk) begin
    if (memWriteEnable) begin
      if (memWriteMask[0]) env_mem[memWriteAddr][9:0]   <= memWriteData[9:0];
      if (memWriteMask[1]) env_mem[memWriteAddr][19:10] <= memWriteData[19:10];
    end
    env_rd1 <= memReadEnable ? env_mem[memReadAddr] : 20'h5A5A5;
    env_rd2 <= env_rd1;
  end
  assign memReadData = env_rd2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wrReqA = 0; wrReqB = 0; rdReqA = 0; rdReqB = 0;
    wrAddrA = 0; wrAddrB = 0; rdAddrA = 0; rdAddrB = 0;
    wrMaskA = 2'b11; wrMaskB = 2'b11; wrDataA = 0; wrDataB = 0;
  endtask

  typedef struct {
    logic [3:0]  req;   // {wrA, wrB, rdA, rdB}
    logic [9:0]  waa, wab, raa, rab;
    logic [3:0]  g;     // {wrGntA, wrGntB, rdGntA, rdGntB}
    logic [19:0] wd;
    logic [9:0]  wa, ra;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] req, input logic [9:0] waa, wab, raa, rab,
                              input logic [3:0] g, input logic [19:0] wd, input logic [9:0] wa, ra);
    vec_t v;
    v.req = req; v.waa = waa; v.wab = wab; v.raa = raa; v.rab = rab;
    v.g = g; v.wd = wd; v.wa = wa; v.ra = ra;
    return v;
  endfunction

  typedef struct {
    int          due;
    logic        own;
    logic [19:0] data;
  } rret_t;

  vec_t        tbl [12];
  rret_t       rq [$];
  logic [19:0] shadow [0:1023];
  logic [19:0] exp32 [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic        pwa, pwb, pra, prb, m_wpri, m_rpri;
    logic [9:0]  rwaa, rwab, rraa, rrab, ewa, era;
    logic [19:0] rwda, rwdb, ewd;
    logic [1:0]  rwma, rwmb, ewm;
    logic        ew, ews, er, ers;

    rst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Clear sweep: requests held high must not be granted
    wrReqA = 1; wrReqB = 1; rdReqA = 1; rdReqB = 1;
    for (int i = 0; i < 1024; i++) begin
      #4;
      chk("clr_busy", busy, 1);
      chk("clr_wen", memWriteEnable, 1);
      chk("clr_waddr", memWriteAddr, i);
      chk("clr_mask", memWriteMask, 2'b11);
      chk("clr_wdata", memWriteData, 0);
      chk("clr_gnts", {wrGntA, wrGntB, rdGntA, rdGntB}, 0);
      chk("clr_ren", memReadEnable, 0);
      chk("clr_rvalid", rdDataValid, 0);
      next_cycle();
    end
    idle_inputs();
    #4;
    chk("run_busy", busy, 0);
    chk("run_idle_wen", memWriteEnable, 0);
    next_cycle();

    tbl[0]  = mk(4'b0000, 0, 0, 0, 0,    4'b0000, 20'h0,     0,  0);
    tbl[1]  = mk(4'b1100, 1, 2, 0, 0,    4'b1000, 20'hA0001, 1,  0);
    tbl[2]  = mk(4'b1100, 1, 2, 0, 0,    4'b0100, 20'hB0002, 2,  0);
    tbl[3]  = mk(4'b1100, 1, 2, 0, 0,    4'b1000, 20'hA0001, 1,  0);
    tbl[4]  = mk(4'b1100, 1, 2, 0, 0,    4'b0100, 20'hB0002, 2,  0);
    tbl[5]  = mk(4'b0100, 0, 3, 0, 0,    4'b0100, 20'hB0003, 3,  0);
    tbl[6]  = mk(4'b0011, 0, 0, 10, 11,  4'b0010, 20'h0,     0,  10);
    tbl[7]  = mk(4'b0011, 0, 0, 10, 11,  4'b0001, 20'h0,     0,  11);
    tbl[8]  = mk(4'b1010, 20, 0, 20, 0,  4'b1000, 20'hA0014, 20, 0);
    tbl[9]  = mk(4'b0111, 0, 20, 20, 21, 4'b0100, 20'hB0014, 20, 0);
    tbl[10] = mk(4'b0010, 0, 0, 20, 0,   4'b0010, 20'h0,     0,  20);
    tbl[11] = mk(4'b1001, 5, 0, 0, 6,    4'b1001, 20'hA0005, 5,  6);

    for (int i = 0; i < 12; i++) begin
      {wrReqA, wrReqB, rdReqA, rdReqB} = tbl[i].req;
      wrAddrA = tbl[i].waa; wrAddrB = tbl[i].wab;
      rdAddrA = tbl[i].raa; rdAddrB = tbl[i].rab;
      wrDataA = 20'hA0000 | 20'(tbl[i].waa);
      wrDataB = 20'hB0000 | 20'(tbl[i].wab);
      #4;
      chk($sformatf("tbl%0d_gnt", i), {wrGntA, wrGntB, rdGntA, rdGntB}, tbl[i].g);
      chk($sformatf("tbl%0d_wen", i), memWriteEnable, |tbl[i].g[3:2]);
      chk($sformatf("tbl%0d_waddr", i), memWriteAddr, tbl[i].wa);
      chk($sformatf("tbl%0d_wdata", i), memWriteData, tbl[i].wd);
      chk($sformatf("tbl%0d_wmask", i), memWriteMask, (|tbl[i].g[3:2]) ? 2'b11 : 2'b00);
      chk($sformatf("tbl%0d_ren", i), memReadEnable, |tbl[i].g[1:0]);
      chk($sformatf("tbl%0d_raddr", i), memReadAddr, tbl[i].ra);
      next_cycle();
    end
    idle_inputs();
    repeat (3) next_cycle();

    // Single read, returned exactly two cycles after grant
    wrReqA = 1; wrAddrA = 5; wrDataA = 20'h12345;
    #4 chk("r30_wgnt", wrGntA, 1);
    next_cycle();
    wrReqA = 0; rdReqA = 1; rdAddrA = 5;
    #4;
    chk("r30_rgnt", rdGntA, 1);
    chk("r30_raddr", memReadAddr, 5);
    chk("r30_valid_t0", rdDataValid, 0);
    next_cycle();
    rdReqA = 0;
    #4 chk("r30_valid_t1", rdDataValid, 0);
    next_cycle();
    #4;
    chk("r30_valid_t2", rdDataValid, 1);
    chk("r30_owner", rdDataOwner, 0);
    chk("r30_data", rdData, 20'h12345);
    next_cycle();
    #4;
    chk("r30_valid_t3", rdDataValid, 0);
    chk("r30_data_zero", rdData, 0);
    next_cycle();

    // Same-address write/read: read deferred, sees new data
    wrReqA = 1; wrAddrA = 7; wrDataA = 20'h7ABCD; rdReqB = 1; rdAddrB = 7;
    #4;
    chk("r31_wgnt", wrGntA, 1);
    chk("r31_rgnt_blocked", rdGntB, 0);
    chk("r31_ren_blocked", memReadEnable, 0);
    chk("r31_raddr_zero", memReadAddr, 0);
    next_cycle();
    wrReqA = 0;
    #4 chk("r31_rgnt_next", rdGntB, 1);
    next_cycle();
    rdReqB = 0;
    next_cycle();
    #4;
    chk("r31_valid", rdDataValid, 1);
    chk("r31_owner", rdDataOwner, 1);
    chk("r31_data", rdData, 20'h7ABCD);
    next_cycle();

    // Back-to-back alternating reads
    for (int k = 0; k < 8; k++) begin
      exp32[k] = 20'h30000 + 20'(k * 17);
      wrReqA = 1; wrAddrA = 10'(100 + k); wrDataA = exp32[k];
      #4 chk("r32_prewrite", wrGntA, 1);
      next_cycle();
    end
    wrReqA = 0;
    for (int k = 0; k < 11; k++) begin
      rdReqA = (k < 8) && (k % 2 == 0);
      rdReqB = (k < 8) && (k % 2 == 1);
      rdAddrA = 10'(100 + k); rdAddrB = 10'(100 + k);
      #4;
      if (k < 8) chk($sformatf("r32_gnt%0d", k), {rdGntA, rdGntB}, (k % 2 == 0) ? 2'b10 : 2'b01);
      if (k >= 2 && k < 10) begin
        chk($sformatf("r32_valid%0d", k - 2), rdDataValid, 1);
        chk($sformatf("r32_owner%0d", k - 2), rdDataOwner, (k - 2) % 2);
        chk($sformatf("r32_data%0d", k - 2), rdData, exp32[k - 2]);
      end else begin
        chk($sformatf("r32_novalid%0d", k), rdDataValid, 0);
      end
      next_cycle();
    end
    idle_inputs();

    // Reset one cycle after a read grant discards it and restarts the clear
    rdReqA = 1; rdAddrA = 5;
    #4 chk("r33_rgnt", rdGntA, 1);
    next_cycle();
    rdReqA = 0; rst = 1; wrReqA = 1;
    #4;
    chk("r33_rst_busy", busy, 1);
    chk("r33_rst_gnts", {wrGntA, wrGntB, rdGntA, rdGntB}, 0);
    chk("r33_rst_valid", rdDataValid, 0);
    chk("r33_rst_ren", memReadEnable, 0);
    next_cycle();
    rst = 0; wrReqA = 0;
    for (int k = 0; k < 6; k++) begin
      #4;
      chk("r33_valid", rdDataValid, 0);
      chk("r33_busy", busy, 1);
      chk("r33_waddr", memWriteAddr, k);
      chk("r33_wen", memWriteEnable, 1);
      next_cycle();
    end
    repeat (1018) next_cycle();
    #4 chk("r33_busy_done", busy, 0);
    next_cycle();

    // Random traffic against reference model
    for (int a = 0; a < 1024; a++) shadow[a] = 20'h0;
    pwa = 0; pwb = 0; pra = 0; prb = 0; m_wpri = 0; m_rpri = 0;
    rwaa = 0; rwab = 0; rraa = 0; rrab = 0; rwda = 0; rwdb = 0; rwma = 0; rwmb = 0;
    for (int c = 0; c < 1500; c++) begin
      if (!pwa && $urandom_range(0, 1) == 1) begin
        pwa = 1; rwaa = 10'($urandom_range(0, 15)); rwda = 20'($urandom); rwma = 2'($urandom_range(1, 3));
      end
      if (!pwb && $urandom_range(0, 1) == 1) begin
        pwb = 1; rwab = 10'($urandom_range(0, 15)); rwdb = 20'($urandom); rwmb = 2'($urandom_range(1, 3));
      end
      if (!pra && $urandom_range(0, 1) == 1) begin pra = 1; rraa = 10'($urandom_range(0, 15)); end
      if (!prb && $urandom_range(0, 1) == 1) begin prb = 1; rrab = 10'($urandom_range(0, 15)); end
      wrReqA = pwa; wrAddrA = rwaa; wrDataA = rwda; wrMaskA = rwma;
      wrReqB = pwb; wrAddrB = rwab; wrDataB = rwdb; wrMaskB = rwmb;
      rdReqA = pra; rdAddrA = rraa; rdReqB = prb; rdAddrB = rrab;
      #4;
      ew  = pwa || pwb;
      ews = (pwa && pwb) ? m_wpri : !pwa;
      ewa = ews ? rwab : rwaa;
      ewd = ews ? rwdb : rwda;
      ewm = ews ? rwmb : rwma;
      ers = (pra && prb) ? m_rpri : !pra;
      era = ers ? rrab : rraa;
      er  = (pra || prb) && !(ew && era == ewa);
      chk("rnd_wgnt", {wrGntA, wrGntB}, {ew && !ews, ew && ews});
      chk("rnd_rgnt", {rdGntA, rdGntB}, {er && !ers, er && ers});
      chk("rnd_wen", memWriteEnable, ew);
      chk("rnd_waddr", memWriteAddr, ew ? ewa : 10'h0);
      chk("rnd_wdata", memWriteData, ew ? ewd : 20'h0);
      chk("rnd_wmask", memWriteMask, ew ? ewm : 2'b00);
      chk("rnd_ren", memReadEnable, er);
      chk("rnd_raddr", memReadAddr, er ? era : 10'h0);
      if (rq.size() > 0 && rq[0].due == c) begin
        chk("rnd_rvalid", rdDataValid, 1);
        chk("rnd_rowner", rdDataOwner, rq[0].own);
        chk("rnd_rdata", rdData, rq[0].data);
        void'(rq.pop_front());
      end else begin
        chk("rnd_rvalid_idle", rdDataValid, 0);
        chk("rnd_rdata_idle", rdData, 0);
      end
      if (er) begin
        rq.push_back('{c + 2, ers, shadow[era]});
        m_rpri = !ers;
        if (ers) prb = 0; else pra = 0;
      end
      if (ew) begin
        if (ewm[0]) shadow[ewa][9:0]   = ewd[9:0];
        if (ewm[1]) shadow[ewa][19:10] = ewd[19:10];
        m_wpri = !ews;
        if (ews) pwb = 0; else pwa = 0;
      end
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
